// File: rtl/scaler_nn_upsample.sv
// Nearest-neighbour upscaler: source lines land in a ping-pong line RAM and are
// replayed with Bresenham-style horizontal and vertical replication.
module scaler_nn_upsample #(
  parameter int MAX_WIDTH = 1920,
  parameter int ADDR_W    = 11
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic        frame_flag,
  input  logic [11:0] s_width,
  input  logic [11:0] s_height,
  input  logic [11:0] t_width,
  input  logic [11:0] t_height,
  input  logic [23:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [23:0] data_out,
  output logic        data_out_valid,
  output logic        frame_flag_out,
  output logic        cfg_err
);

  localparam logic [11:0] MAX_W12 = 12'(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, EMIT, LINE_END} rd_state_e;

  rd_state_e   state_q, state_d;
  logic [11:0] sw_q, sw_d, sh_q, sh_d, tw_q, tw_d, th_q, th_d;
  logic        cfg_err_q, cfg_err_d;
  logic        wr_active_q, wr_active_d;
  logic        wb_q, wb_d, rb_q, rb_d;
  logic [1:0]  full_q, full_d;
  logic [11:0] wx_q, wx_d, wline_q, wline_d;
  logic [12:0] h_acc_q, h_acc_d, v_acc_q, v_acc_d;
  logic [11:0] h_idx_q, h_idx_d, ox_q, ox_d, oline_q, oline_d;
  logic        ffo_s1_q, ffo_s1_d;
  logic        rd_vld_q, rd_vld_d;
  logic        frame_flag_out_q, frame_flag_out_d;
  logic        data_out_valid_q, data_out_valid_d;
  logic [23:0] data_out_q, data_out_d;

  logic [23:0] mem0 [MAX_WIDTH];
  logic [23:0] mem1 [MAX_WIDTH];
  logic [23:0] ram_q;

  logic        wr_en, rd_en, size_err, rb_next;
  logic [12:0] h_sum, v_sum;

  assign data_in_ready  = cfg_err_q | (wr_active_q & ~full_q[wb_q]);
  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign frame_flag_out = frame_flag_out_q;
  assign cfg_err        = cfg_err_q;

  always_comb begin
    state_d          = state_q;
    sw_d             = sw_q;
    sh_d             = sh_q;
    tw_d             = tw_q;
    th_d             = th_q;
    cfg_err_d        = cfg_err_q;
    wr_active_d      = wr_active_q;
    wb_d             = wb_q;
    rb_d             = rb_q;
    full_d           = full_q;
    wx_d             = wx_q;
    wline_d          = wline_q;
    h_acc_d          = h_acc_q;
    v_acc_d          = v_acc_q;
    h_idx_d          = h_idx_q;
    ox_d             = ox_q;
    oline_d          = oline_q;
    rb_next          = rb_q;
    h_sum            = h_acc_q + {1'b0, sw_q};
    v_sum            = v_acc_q + {1'b0, sh_q};
    size_err         = (s_width == 12'd0) || (s_height == 12'd0) ||
                       (t_width == 12'd0) || (t_height == 12'd0) ||
                       (s_width > t_width) || (s_height > t_height) ||
                       (t_width > MAX_W12);
    wr_en            = wr_active_q & ~cfg_err_q & ~full_q[wb_q] & data_in_valid;
    rd_en            = (state_q == EMIT);
    rd_vld_d         = rd_en;
    ffo_s1_d         = 1'b0;
    frame_flag_out_d = ffo_s1_q;
    data_out_valid_d = rd_vld_q;
    data_out_d       = rd_vld_q ? ram_q : 24'd0;

    if (wr_en) begin
      if (wx_q == sw_q - 12'd1) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wx_d         = 12'd0;
        wline_d      = wline_q + 12'd1;
        if (wline_q + 12'd1 == sh_q) wr_active_d = 1'b0;
      end else begin
        wx_d = wx_q + 12'd1;
      end
    end

    case (state_q)
      IDLE: ;
      WAIT_LINE: begin
        if (full_q[rb_q]) begin
          state_d  = EMIT;
          ffo_s1_d = (oline_q == 12'd0);
        end
      end
      EMIT: begin
        if (h_sum >= {1'b0, tw_q}) begin
          h_acc_d = h_sum - {1'b0, tw_q};
          h_idx_d = h_idx_q + 12'd1;
        end else begin
          h_acc_d = h_sum;
        end
        ox_d = ox_q + 12'd1;
        if (ox_q == tw_q - 12'd1) state_d = LINE_END;
      end
      LINE_END: begin
        h_acc_d = 13'd0;
        h_idx_d = 12'd0;
        ox_d    = 12'd0;
        if (v_sum >= {1'b0, th_q}) begin
          v_acc_d      = v_sum - {1'b0, th_q};
          full_d[rb_q] = 1'b0;
          rb_next      = ~rb_q;
        end else begin
          v_acc_d = v_sum;
        end
        rb_d    = rb_next;
        oline_d = oline_q + 12'd1;
        if (oline_d == th_q)       state_d = IDLE;
        else if (full_d[rb_next])  state_d = EMIT;
        else                       state_d = WAIT_LINE;
      end
      default: state_d = IDLE;
    endcase

    // A new frame restarts everything and kills any output still in the pipe
    if (frame_flag) begin
      sw_d             = s_width;
      sh_d             = s_height;
      tw_d             = t_width;
      th_d             = t_height;
      cfg_err_d        = size_err;
      wr_active_d      = ~size_err;
      wb_d             = 1'b0;
      rb_d             = 1'b0;
      full_d           = 2'b00;
      wx_d             = 12'd0;
      wline_d          = 12'd0;
      h_acc_d          = 13'd0;
      v_acc_d          = 13'd0;
      h_idx_d          = 12'd0;
      ox_d             = 12'd0;
      oline_d          = 12'd0;
      state_d          = WAIT_LINE;
      rd_vld_d         = 1'b0;
      ffo_s1_d         = 1'b0;
      frame_flag_out_d = 1'b0;
      data_out_valid_d = 1'b0;
      data_out_d       = 24'd0;
    end
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      sw_q             <= 12'd0;
      sh_q             <= 12'd0;
      tw_q             <= 12'd0;
      th_q             <= 12'd0;
      cfg_err_q        <= 1'b0;
      wr_active_q      <= 1'b0;
      wb_q             <= 1'b0;
      rb_q             <= 1'b0;
      full_q           <= 2'b00;
      wx_q             <= 12'd0;
      wline_q          <= 12'd0;
      h_acc_q          <= 13'd0;
      v_acc_q          <= 13'd0;
      h_idx_q          <= 12'd0;
      ox_q             <= 12'd0;
      oline_q          <= 12'd0;
      ffo_s1_q         <= 1'b0;
      rd_vld_q         <= 1'b0;
      frame_flag_out_q <= 1'b0;
      data_out_valid_q <= 1'b0;
      data_out_q       <= 24'd0;
    end else begin
      state_q          <= state_d;
      sw_q             <= sw_d;
      sh_q             <= sh_d;
      tw_q             <= tw_d;
      th_q             <= th_d;
      cfg_err_q        <= cfg_err_d;
      wr_active_q      <= wr_active_d;
      wb_q             <= wb_d;
      rb_q             <= rb_d;
      full_q           <= full_d;
      wx_q             <= wx_d;
      wline_q          <= wline_d;
      h_acc_q          <= h_acc_d;
      v_acc_q          <= v_acc_d;
      h_idx_q          <= h_idx_d;
      ox_q             <= ox_d;
      oline_q          <= oline_d;
      ffo_s1_q         <= ffo_s1_d;
      rd_vld_q         <= rd_vld_d;
      frame_flag_out_q <= frame_flag_out_d;
      data_out_valid_q <= data_out_valid_d;
      data_out_q       <= data_out_d;
    end
  end

  // Line RAM banks; left without reset so they map onto block RAM
  always_ff @(posedge pix_clk) begin
    if (wr_en) begin
      if (wb_q) mem1[wx_q[ADDR_W-1:0]] <= data_in;
      else      mem0[wx_q[ADDR_W-1:0]] <= data_in;
    end
    if (rd_en) ram_q <= rb_q ? mem1[h_idx_q[ADDR_W-1:0]] : mem0[h_idx_q[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_scaler_nn_upsample.sv
// Self-checking bench for scaler_nn_upsample: table-driven frames, random frames
// against a floor(i*s/t) nearest-neighbour model, plus abort and reset sequences.
module tb_scaler_nn_upsample;

  logic        pix_clk = 1'b0;
  logic        rst_n;
  logic        frame_flag;
  logic [11:0] s_width, s_height, t_width, t_height;
  logic [23:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [23:0] data_out;
  logic        data_out_valid;
  logic        frame_flag_out;
  logic        cfg_err;

  always #5 pix_clk = ~pix_clk;

  scaler_nn_upsample dut (
    .pix_clk        (pix_clk),
    .rst_n          (rst_n),
    .frame_flag     (frame_flag),
    .s_width        (s_width),
    .s_height       (s_height),
    .t_width        (t_width),
    .t_height       (t_height),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .frame_flag_out (frame_flag_out),
    .cfg_err        (cfg_err)
  );

  typedef struct {
    int sw;
    int sh;
    int tw;
    int th;
    bit toggle;
    bit exp_err;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [23:0] out_q[$];
  int          out_cyc[$];
  int          ffo_cnt   = 0;
  int          ffo_cyc   = 0;
  int          zero_viol = 0;

  logic [23:0] src[$];
  int          base, ffo_base, zero_base;
  int          line0_acc;

  always @(posedge pix_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge pix_clk) begin
    if (data_out_valid) begin
      out_q.push_back(data_out);
      out_cyc.push_back(cyc);
    end else if (data_out != 24'd0) begin
      zero_viol++;
    end
    if (frame_flag_out) begin
      ffo_cnt++;
      ffo_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_frame(input int sw, input int sh, input int tw, input int th);
    @(posedge pix_clk); #1;
    frame_flag = 1'b1;
    s_width    = 12'(sw);
    s_height   = 12'(sh);
    t_width    = 12'(tw);
    t_height   = 12'(th);
    @(posedge pix_clk); #1;
    frame_flag = 1'b0;
    base      = out_q.size();
    ffo_base  = ffo_cnt;
    zero_base = zero_viol;
  endtask

  task automatic fill_src(input int n, input bit rnd);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(rnd ? 24'($urandom) : 24'(i));
  endtask

  // Feeds the whole source frame; must be entered just after a rising edge
  task automatic apply_stimulus(input int sw, input int sh, input bit toggle);
    int  idx = 0;
    int  g   = 0;
    bit  acc;
    line0_acc = -100;
    while (idx < sw * sh && g < 20000) begin
      data_in_valid = toggle ? (g % 2 == 0) : 1'b1;
      data_in       = src[idx];
      @(negedge pix_clk);
      acc = data_in_valid && data_in_ready;
      if (acc && idx == sw - 1) line0_acc = cyc + 1;
      @(posedge pix_clk); #1;
      if (acc) idx++;
      g++;
    end
    data_in_valid = 1'b0;
    data_in       = 24'd0;
    check_val("all_pixels_accepted", idx, sw * sh);
  endtask

  task automatic check_output(input int sw, input int sh, input int tw, input int th);
    int n = tw * th;
    int g = 0;
    int avail, mism, cont, y, x;
    logic [23:0] expv;
    check_val("ready_low_after_frame", data_in_ready, 0);
    while (out_q.size() - base < n && g < 20000) begin
      @(negedge pix_clk);
      g++;
    end
    repeat (10) @(negedge pix_clk);
    avail = out_q.size() - base;
    check_val("out_count", avail, n);
    if (avail > n) avail = n;
    mism = 0;
    cont = 0;
    for (int i = 0; i < avail; i++) begin
      y    = i / tw;
      x    = i % tw;
      expv = src[(y * sh / th) * sw + (x * sw / tw)];
      if (out_q[base + i] !== expv) begin
        if (mism == 0)
          $display("[TB] first bad pixel %0d (line %0d col %0d): got %h expected %h",
                   i, y, x, out_q[base + i], expv);
        mism++;
      end
      if (x > 0 && out_cyc[base + i] != out_cyc[base + y * tw] + x) cont++;
    end
    check_val("pixel_mismatches", mism, 0);
    check_val("line_contiguous_errors", cont, 0);
    check_val("ffo_pulses", ffo_cnt - ffo_base, 1);
    check_val("zero_when_invalid_errors", zero_viol - zero_base, 0);
    check_val("cfg_err_legal", cfg_err, 0);
    if (avail > 0) begin
      check_val("first_valid_latency", out_cyc[base] - line0_acc, 3);
      check_val("ffo_lead", out_cyc[base] - ffo_cyc, 1);
    end
  endtask

  task automatic run_legal(input int sw, input int sh, input int tw, input int th,
                           input bit toggle, input bit rnd);
    fill_src(sw * sh, rnd);
    start_frame(sw, sh, tw, th);
    apply_stimulus(sw, sh, toggle);
    check_output(sw, sh, tw, th);
  endtask

  task automatic run_err(input int sw, input int sh, input int tw, input int th);
    fill_src(sw * sh, 1'b1);
    start_frame(sw, sh, tw, th);
    @(negedge pix_clk);
    check_val("cfg_err_set", cfg_err, 1);
    check_val("ready_drain", data_in_ready, 1);
    @(posedge pix_clk); #1;
    if (sw * sh > 0) apply_stimulus(sw, sh, 1'b0);
    repeat (40) @(negedge pix_clk);
    check_val("err_out_count", out_q.size() - base, 0);
    check_val("err_ffo_pulses", ffo_cnt - ffo_base, 0);
    check_val("cfg_err_holds", cfg_err, 1);
    @(posedge pix_clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_data_out"}, data_out, 0);
    check_val({tag, "_valid"}, data_out_valid, 0);
    check_val({tag, "_ffo"}, frame_flag_out, 0);
    check_val({tag, "_cfg_err"}, cfg_err, 0);
    check_val({tag, "_ready"}, data_in_ready, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int g;
    int sw, sh, tw, th;
    rst_n         = 1'b1;
    frame_flag    = 1'b0;
    s_width       = 12'd0;
    s_height      = 12'd0;
    t_width       = 12'd0;
    t_height      = 12'd0;
    data_in       = 24'd0;
    data_in_valid = 1'b0;

    vecs[0] = '{4, 2, 8, 4, 1'b0, 1'b0};
    vecs[1] = '{3, 1, 5, 1, 1'b0, 1'b0};
    vecs[2] = '{6, 3, 6, 3, 1'b1, 1'b0};
    vecs[3] = '{10, 1, 8, 1, 1'b0, 1'b1};
    vecs[4] = '{5, 2, 7, 3, 1'b0, 1'b0};
    vecs[5] = '{0, 2, 4, 4, 1'b0, 1'b1};
    vecs[6] = '{4, 5, 4, 4, 1'b0, 1'b1};
    vecs[7] = '{4, 2, 2000, 4, 1'b0, 1'b1};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge pix_clk);
    check_all_zero("reset");
    @(posedge pix_clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge pix_clk);
    check_all_zero("idle_after_reset");
    @(posedge pix_clk); #1;

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].exp_err) run_err(vecs[v].sw, vecs[v].sh, vecs[v].tw, vecs[v].th);
      else run_legal(vecs[v].sw, vecs[v].sh, vecs[v].tw, vecs[v].th, vecs[v].toggle, 1'b0);
    end

    for (int r = 0; r < 6; r++) begin
      sw = $urandom_range(1, 12);
      tw = $urandom_range(sw, 24);
      sh = $urandom_range(1, 6);
      th = $urandom_range(sh, 10);
      run_legal(sw, sh, tw, th, 1'(($urandom % 2)), 1'b1);
    end

    // Abort a frame partway through its second output line
    fill_src(8, 1'b0);
    start_frame(4, 2, 8, 4);
    apply_stimulus(4, 2, 1'b0);
    g = 0;
    while (out_q.size() - base < 10 && g < 2000) begin
      @(negedge pix_clk);
      g++;
    end
    check_val("abort_reached_line1", (out_q.size() - base >= 10) ? 1 : 0, 1);
    fill_src(8, 1'b1);
    start_frame(4, 2, 8, 4);
    @(negedge pix_clk);
    check_val("abort_valid_low", data_out_valid, 0);
    @(posedge pix_clk); #1;
    apply_stimulus(4, 2, 1'b0);
    check_output(4, 2, 8, 4);

    // Asynchronous reset in the middle of output
    fill_src(8, 1'b1);
    start_frame(4, 2, 8, 4);
    apply_stimulus(4, 2, 1'b0);
    g = 0;
    while (out_q.size() - base < 3 && g < 2000) begin
      @(negedge pix_clk);
      g++;
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    @(posedge pix_clk); #1;
    rst_n = 1'b1;
    base     = out_q.size();
    ffo_base = ffo_cnt;
    repeat (40) @(negedge pix_clk);
    check_val("post_reset_out_count", out_q.size() - base, 0);
    check_val("post_reset_ffo", ffo_cnt - ffo_base, 0);
    check_val("post_reset_ready", data_in_ready, 0);
    @(posedge pix_clk); #1;

    run_legal(3, 1, 5, 1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scaler_nn_upsample.md
Name: scaler_nn_upsample

Overview:
- Nearest-neighbour upscaler for the HDMI video path; sits directly upstream of the centre-crop scaler.
- Takes an s_width x s_height RGB888 source frame and produces a t_width x t_height stream.
- Buffers source lines in a ping-pong line RAM. Pixels are replicated horizontally and lines vertically by integer DDA (Bresenham) accumulators, with no dividers.
- Emits a frame-start pulse aligned to the output stream for the downstream crop stage.

Parameters:
- MAX_WIDTH, 1920, maximum source line length; each line RAM bank is sized to this depth.
- ADDR_W, 11, line RAM address width; must satisfy 2^ADDR_W >= MAX_WIDTH.

Ports:
- pix_clk  input  1  pixel clock; all logic in this domain.
- rst_n  input  1  asynchronous active-low reset.
- frame_flag  input  1  one-cycle pulse, before the first source pixel of a frame.
- s_width  input  12  source width; latched on frame_flag.
- s_height  input  12  source height; latched on frame_flag.
- t_width  input  12  target width; latched on frame_flag.
- t_height  input  12  target height; latched on frame_flag.
- data_in  input  24  source pixel, RGB888.
- data_in_valid  input  1  source pixel valid.
- data_in_ready  output  1  source pixel accepted on a cycle when valid and ready are both high.
- data_out  output  24  upscaled pixel.
- data_out_valid  output  1  upscaled pixel valid; downstream has no backpressure.
- frame_flag_out  output  1  one-cycle pulse, one cycle before the first data_out_valid of a frame.
- cfg_err  output  1  latched sizes are illegal for the current frame.

Behaviour:
- Reset values:
  - data_out = 0, data_out_valid = 0, frame_flag_out = 0, cfg_err = 0, data_in_ready = 0.
  - Both bank-full flags cleared, write bank = read bank = 0.
  - Reader in IDLE.
- frame_flag, at any time including mid-frame:
  - Latches the four sizes.
  - Clears all counters, both DDA accumulators and both full flags; sets write bank = read bank = 0.
  - Reader goes to WAIT_LINE.
  - Any in-flight output is aborted; data_out_valid is 0 from the following cycle.
- Config check on the latched values:
  - cfg_err = 1 if any size is 0, s_width > t_width, s_height > t_height, or t_width > MAX_WIDTH.
  - While cfg_err = 1: data_in_ready = 1 (input is drained and discarded), no output, no frame_flag_out.
  - cfg_err holds until the next frame_flag.
- Writer:
  - Writes accepted pixels into bank wb at address wx, with wx counting 0..s_width-1.
  - data_in_ready = writer active AND !full[wb].
  - On accepting pixel s_width-1: full[wb] <= 1, wb toggles, wx <= 0, and the source line counter increments.
  - After s_height lines, the writer is inactive (ready = 0) until the next frame_flag.
- Reader FSM:
  - IDLE: waits for frame_flag.
  - WAIT_LINE: goes to EMIT when full[rb] = 1. On the first output line of a frame, frame_flag_out pulses on this transition.
  - EMIT: issues one RAM read per cycle at address h_idx for t_width cycles.
    - Horizontal DDA per output pixel: h_acc += s_width; if h_acc >= t_width then h_acc -= t_width and h_idx++.
    - h_acc and h_idx are cleared at line start.
    - After the read for output pixel t_width-1, go to LINE_END.
  - LINE_END: one cycle.
    - Vertical DDA: v_acc += s_height; if v_acc >= t_height then v_acc -= t_height, full[rb] <= 0 and rb toggles.
    - Output line counter increments. At t_height go to IDLE; otherwise go to WAIT_LINE (or straight to EMIT if the next bank is already full).
- Accumulators are 13 bits wide so there is no overflow.
- The first output pixel uses source index 0 and the first output line uses source line 0. Exactly s_height source lines are released per frame.
- Output timing:
  - RAM read latency is 1 cycle; data_out and data_out_valid are registered from the read.
  - data_out = 0 whenever valid is 0.
  - First data_out_valid of a frame occurs exactly 3 cycles after the edge that accepts the last pixel of source line 0.
  - Within a line, data_out_valid is continuous for t_width cycles.
- A write full-set and a read full-clear in the same cycle always target different banks; both take effect.
- Reset mid-operation: immediate return to reset values; RAM contents are don't-care.

Test Plan:
- 4x2 -> 8x4 (source pixels 0..7): each output line 0 and 1 is 0,0,1,1,2,2,3,3; lines 2 and 3 are 4,4,5,5,6,6,7,7. frame_flag_out fires once, 1 cycle before the first valid.
- 3x1 -> 5x1 (source pixels A,B,C): output is A,A,B,B,C. Source line released once; data_in_ready deasserts after 3 accepts.
- 6x3 -> 6x3 identity with data_in_valid toggling every other cycle: output equals input. data_in_ready drops to 0 only while both banks are full.
- s_width=10, t_width=8: cfg_err=1, data_in_ready=1, data_out_valid never asserted. The next legal frame_flag clears cfg_err and output resumes.
- frame_flag asserted mid-EMIT of line 1: data_out_valid is 0 the following cycle. The new frame's first output is source pixel 0 of the new frame, with frame_flag_out preceding it by 1 cycle.
- rst_n pulsed low mid-frame: all outputs return to 0 asynchronously. There is no output until the next frame_flag.
